// File: rtl/iir_dac_tx.sv
// Serialises signed IIR samples into 16-bit {CMD, data, 0000} SPI frames for a DAC.
// Define DAC_TX_OFFSET_BIN_EN to send the data byte as offset binary.
module iir_dac_tx #(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = 4'b0011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    input  logic       clr_ovf,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_sdo,
    output logic       busy,
    output logic       frame_done,
    output logic       ovf
);

    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [4:0]    r_bit;
    logic [15:0]   r_shift;
    logic          r_cs_n;
    logic          r_sclk;
    logic          r_sdo;
    logic          r_done;
    logic          r_ovf;

    logic [7:0]    w_byte;
    logic [15:0]   w_frame;
    logic          w_idle;
    logic          w_ovr;

`ifdef DAC_TX_OFFSET_BIN_EN
    assign w_byte = {~din[7], din[6:0]};
`else
    assign w_byte = din;
`endif

    assign w_frame = {CMD, w_byte, 4'b0000};
    assign w_idle  = (r_state == IDLE);
    assign w_ovr   = din_vld && !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A new overrun beats a simultaneous clear
            if (w_ovr) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (din_vld) begin
                        r_state <= LOAD;
                        r_cs_n  <= 1'b0;
                        r_shift <= w_frame;
                        r_sdo   <= w_frame[15];
                        r_div   <= '0;
                        r_bit   <= '0;
                    end
                end
                LOAD: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling sclk: only point where sdo may move
                            r_sclk <= 1'b0;
                            if (r_bit == 5'd15) begin
                                r_state <= HOLD;
                                r_bit   <= '0;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_shift <= {r_shift[14:0], 1'b0};
                                r_sdo   <= r_shift[14];
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= DONE;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_sdo   <= 1'b0;
                        r_shift <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign din_rdy    = w_idle;
    assign busy       = !w_idle;
    assign dac_cs_n   = r_cs_n;
    assign dac_sclk   = r_sclk;
    assign dac_sdo    = r_sdo;
    assign frame_done = r_done;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_iir_dac_tx.sv
// Bench for iir_dac_tx: frame capture on sclk rises checked against a
// scoreboard of expected frames; second instance runs CLK_DIV=1 back-to-back.
module tb_iir_dac_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_vld;
    logic       clr_ovf;
    logic       din_rdy, dac_cs_n, dac_sclk, dac_sdo, busy, frame_done, ovf;

    logic [7:0] din1;
    logic       din_vld1;
    logic       din_rdy1, cs_n1, sclk1, sdo1, busy1, done1, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iir_dac_tx #(.CLK_DIV(4), .CMD(4'b0011)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .din_rdy(din_rdy), .clr_ovf(clr_ovf), .dac_cs_n(dac_cs_n),
        .dac_sclk(dac_sclk), .dac_sdo(dac_sdo), .busy(busy),
        .frame_done(frame_done), .ovf(ovf)
    );

    iir_dac_tx #(.CLK_DIV(1), .CMD(4'b0011)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_vld(din_vld1),
        .din_rdy(din_rdy1), .clr_ovf(1'b0), .dac_cs_n(cs_n1),
        .dac_sclk(sclk1), .dac_sdo(sdo1), .busy(busy1),
        .frame_done(done1), .ovf(ovf1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame(input logic [7:0] d);
`ifdef DAC_TX_OFFSET_BIN_EN
        return {4'b0011, ~d[7], d[6:0], 4'b0000};
`else
        return {4'b0011, d, 4'b0000};
`endif
    endfunction

    logic [15:0] q[$];
    logic [15:0] q1[$];

    // Monitor for the CLK_DIV=4 instance
    logic [15:0] m_word, m_e;
    int          m_bits, m_low, n_done;
    bit          m_bad;
    logic        p_sclk, p_cs_n, p_sdo;

    initial begin
        m_word = '0; m_bits = 0; m_low = 0; n_done = 0; m_bad = 0;
        p_sclk = 1'b0; p_cs_n = 1'b1; p_sdo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_word = '0; m_bits = 0; m_low = 0; m_bad = 0;
            end else begin
                if (!dac_cs_n) m_low++;
                if (dac_sclk && !p_sclk) begin
                    m_word = {m_word[14:0], dac_sdo};
                    m_bits++;
                end
                if (dac_sclk && p_sclk && dac_sdo !== m_word[0]) m_bad = 1;
                if (!dac_cs_n && !p_cs_n && dac_sdo !== p_sdo &&
                    !(p_sclk && !dac_sclk)) m_bad = 1;
                if (frame_done) begin
                    check("sb_pending", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        m_e = q.pop_front();
                        check("frame_bits", int'(m_word), int'(m_e));
                    end
                    check("cs_low_cycles", m_low, 133);
                    check("sclk_rises", m_bits, 16);
                    check("sdo_stable", int'(m_bad), 0);
                    n_done++;
                    m_word = '0; m_bits = 0; m_low = 0; m_bad = 0;
                end
            end
            p_sclk = dac_sclk; p_cs_n = dac_cs_n; p_sdo = dac_sdo;
        end
    end

    // Monitor for the CLK_DIV=1 instance
    logic [15:0] m1_word, m1_e;
    int          m1_bits, m1_low, m1_tog, m1_hi, n1_done;
    logic        p1_sclk, p1_cs_n;

    initial begin
        m1_word = '0; m1_bits = 0; m1_low = 0; m1_tog = 0; m1_hi = 0;
        n1_done = 0; p1_sclk = 1'b0; p1_cs_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m1_word = '0; m1_bits = 0; m1_low = 0; m1_tog = 0; m1_hi = 0;
            end else begin
                if (cs_n1) begin
                    m1_hi++;
                end else begin
                    if (p1_cs_n && n1_done > 0) check("b2b_gap", m1_hi, 2);
                    m1_hi = 0;
                    m1_low++;
                    if (sclk1 !== p1_sclk) m1_tog++;
                end
                if (sclk1 && !p1_sclk) begin
                    m1_word = {m1_word[14:0], sdo1};
                    m1_bits++;
                end
                if (done1) begin
                    check("b2b_pending", int'(q1.size() > 0), 1);
                    if (q1.size() > 0) begin
                        m1_e = q1.pop_front();
                        check("b2b_frame", int'(m1_word), int'(m1_e));
                    end
                    check("b2b_cs_low", m1_low, 34);
                    check("b2b_sclk_toggles", m1_tog, 32);
                    check("b2b_rises", m1_bits, 16);
                    n1_done++;
                    m1_word = '0; m1_bits = 0; m1_low = 0; m1_tog = 0;
                end
            end
            p1_sclk = sclk1; p1_cs_n = cs_n1;
        end
    end

    task automatic send(input logic [7:0] d, input logic [15:0] e);
        int t = 0;
        while (!din_rdy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("rdy_before_send", int'(din_rdy), 1);
        din     = d;
        din_vld = 1'b1;
        q.push_back(e);
        @(negedge clk);
        din_vld = 1'b0;
        check("load_cs_low", int'(dac_cs_n), 0);
        check("load_busy", int'(busy), 1);
        check("load_rdy", int'(din_rdy), 0);
    endtask

    task automatic wait_done(input string name);
        int prev = n_done;
        int t = 0;
        while (n_done == prev && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(name, int'(n_done != prev), 1);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] f;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t;
        int sent;
`ifdef DAC_TX_OFFSET_BIN_EN
        tbl[0] = '{8'h81, 16'h3010};
        tbl[1] = '{8'h7F, 16'h3FF0};
        tbl[2] = '{8'h00, 16'h3800};
        tbl[3] = '{8'h05, 16'h3850};
        tbl[4] = '{8'hA5, 16'h3250};
        tbl[5] = '{8'hFF, 16'h37F0};
`else
        tbl[0] = '{8'h81, 16'h3810};
        tbl[1] = '{8'h7F, 16'h37F0};
        tbl[2] = '{8'h00, 16'h3000};
        tbl[3] = '{8'h05, 16'h3050};
        tbl[4] = '{8'hA5, 16'h3A50};
        tbl[5] = '{8'hFF, 16'h3FF0};
`endif
        din = '0; din_vld = 1'b0; clr_ovf = 1'b0;
        din1 = '0; din_vld1 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(dac_cs_n), 1);
        check("rst_sclk", int'(dac_sclk), 0);
        check("rst_sdo", int'(dac_sdo), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_rdy", int'(din_rdy), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_cs_n1", int'(cs_n1), 1);
        check("rst_rdy1", int'(din_rdy1), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].d, tbl[i].f);
            wait_done("tbl_frame_done");
            check("done_cycle_rdy", int'(din_rdy), 0);
            check("done_cycle_cs_n", int'(dac_cs_n), 1);
            @(negedge clk);
            check("recover_rdy", int'(din_rdy), 1);
            check("done_one_cycle", int'(frame_done), 0);
        end

        // Overrun mid-frame, then clear racing a second overrun
        send(8'h5A, exp_frame(8'h5A));
        repeat (9) @(negedge clk);
        din = 8'hFF; din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        check("ovf_set", int'(ovf), 1);
        check("ovf_busy", int'(busy), 1);
        clr_ovf = 1'b1; din_vld = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0; din_vld = 1'b0;
        check("ovf_clr_vs_ovr", int'(ovf), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", int'(ovf), 0);
        wait_done("ovf_frame_done");
        @(negedge clk);

        // Reset during the eighth bit aborts the frame
        send(8'h3C, exp_frame(8'h3C));
        t = 0;
        while (m_bits < 8 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reached_bit7", int'(m_bits >= 8), 1);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", int'(dac_cs_n), 1);
        check("abort_sclk", int'(dac_sclk), 0);
        check("abort_sdo", int'(dac_sdo), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rdy", int'(din_rdy), 1);
        q.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", int'(frame_done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", int'(frame_done), 0);
`ifdef DAC_TX_OFFSET_BIN_EN
        send(8'h05, 16'h3850);
`else
        send(8'h05, 16'h3050);
`endif
        wait_done("post_rst_frame_done");
        @(negedge clk);

        // CLK_DIV=1 instance, strobing whenever it becomes ready
        sent = 0;
        t = 0;
        while (n1_done < 4 && t < 1000) begin
            @(negedge clk);
            #1;
            if (din_rdy1 && sent < 4) begin
                din1     = 8'(17 * (sent + 3));
                din_vld1 = 1'b1;
                q1.push_back(exp_frame(din1));
                sent++;
            end else begin
                din_vld1 = 1'b0;
            end
            t++;
        end
        din_vld1 = 1'b0;
        check("b2b_frames", n1_done, 4);
        check("b2b_ovf", int'(ovf1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
